seg7_scan_display: RTL and testbench



---
 rtl/seg7_scan_display.sv | 137 +++++++++++++
 tb/tb_seg7_scan_display.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed driver for an N-digit common seven-segment display.
// Snapshots value/dots/digit_en once per scan frame and blanks every digit for the
// first BLANK_CYCLES of each slot to suppress ghosting.
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to darken the digits above the
// highest nonzero snapshot nibble (digit 0 always stays lit).
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous reset, active-high
//   value     in   4*N_DIGITS hex nibbles, nibble i shown on digit i
//   dots      in   N_DIGITS, 1 = decimal point lit on digit i
//   digit_en  in   N_DIGITS, 1 = digit i displayed
//   abcdefgh  out  8 segment lines, active-low (bit7=a .. bit1=g, bit0=dot)
//   digit     out  N_DIGITS digit selects, active-low, at most one low
//   scan_idx  out  index of the current slot
module seg7_scan_display #(
   parameter int unsigned N_DIGITS     = 4,
   parameter int unsigned DIGIT_PERIOD = 50000,
   parameter int unsigned BLANK_CYCLES = 1000,
   localparam int unsigned IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]   dots,
   input  logic [N_DIGITS-1:0]   digit_en,
   output logic [7:0]            abcdefgh,
   output logic [N_DIGITS-1:0]   digit,
   output logic [IDX_W-1:0]      scan_idx
);

   localparam int unsigned PRE_W = $clog2(DIGIT_PERIOD);

   logic [PRE_W-1:0]      prescaler;
   logic                  frame_start;
   logic [4*N_DIGITS-1:0] shadow_value;
   logic [N_DIGITS-1:0]   shadow_dots;
   logic [N_DIGITS-1:0]   shadow_en;

   logic                  last_cycle;
   logic                  lit;
   logic [3:0]            nibble;
   logic [7:0]            seg_full;
   logic [7:0]            seg_next;
   logic [N_DIGITS-1:0]   digit_next;

   // Active-high a..g in bits 7..1, bit 0 left clear for the dot.
   function automatic logic [7:0] seg7(input logic [3:0] hex);
      case (hex)
         4'h0: seg7 = 8'hFC;
         4'h1: seg7 = 8'h60;
         4'h2: seg7 = 8'hDA;
         4'h3: seg7 = 8'hF2;
         4'h4: seg7 = 8'h66;
         4'h5: seg7 = 8'hB6;
         4'h6: seg7 = 8'hBE;
         4'h7: seg7 = 8'hE0;
         4'h8: seg7 = 8'hFE;
         4'h9: seg7 = 8'hF6;
         4'hA: seg7 = 8'hEE;
         4'hB: seg7 = 8'h3E;
         4'hC: seg7 = 8'h9C;
         4'hD: seg7 = 8'h7A;
         4'hE: seg7 = 8'h9E;
         default: seg7 = 8'h8E;
      endcase
   endfunction

   assign last_cycle = (prescaler == PRE_W'(DIGIT_PERIOD - 1));

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [N_DIGITS-1:0] keep;
   logic                above;

   // Digit i stays lit when any nibble at or above i is nonzero; digit 0 always stays.
   always_comb begin
      keep  = '0;
      above = 1'b0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         above   = above | (|shadow_value[4*i +: 4]);
         keep[i] = above || (i == 0);
      end
   end
`endif

   // Next-cycle segment/digit pattern from the current slot and the snapshot.
   always_comb begin
      nibble     = shadow_value[4*int'(scan_idx) +: 4];
      seg_full   = seg7(nibble);
      lit        = shadow_en[scan_idx] && (32'(prescaler) >= BLANK_CYCLES);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lit        = lit && keep[scan_idx];
`endif
      digit_next = '1;
      seg_next   = 8'hFF;
      if (lit) begin
         digit_next = ~(N_DIGITS'(1) << scan_idx);
         seg_next   = ~{seg_full[7:1], shadow_dots[scan_idx]};
      end
   end

   // Prescaler, slot index, frame snapshot and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler    <= '0;
         scan_idx     <= '0;
         frame_start  <= 1'b1;
         shadow_value <= '0;
         shadow_dots  <= '0;
         shadow_en    <= '0;
         abcdefgh     <= 8'hFF;
         digit        <= '1;
      end else begin
         if (frame_start) begin
            shadow_value <= value;
            shadow_dots  <= dots;
            shadow_en    <= digit_en;
            frame_start  <= 1'b0;
         end
         if (last_cycle) begin
            prescaler <= '0;
            if (scan_idx == IDX_W'(N_DIGITS - 1)) begin
               scan_idx    <= '0;
               frame_start <= 1'b1;
            end else begin
               scan_idx <= scan_idx + IDX_W'(1);
            end
         end else begin
            prescaler <= prescaler + PRE_W'(1);
         end
         abcdefgh <= seg_next;
         digit    <= digit_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed checks of seg7_scan_display with N_DIGITS=4,
// DIGIT_PERIOD=4, BLANK_CYCLES=1. Covers reset, a plain frame, mid-frame input
// changes, dots and disabled digits, reset mid-scan and leading-zero handling
// (expectations follow SEG7_LEADING_ZERO_BLANK_EN when it is defined).
module tb_seg7_scan_display;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value;
   logic [3:0]  dots;
   logic [3:0]  digit_en;
   logic [7:0]  abcdefgh;
   logic [3:0]  digit;
   logic [1:0]  scan_idx;

   int checks = 0;
   int passed = 0;

   seg7_scan_display #(
      .N_DIGITS    (4),
      .DIGIT_PERIOD(4),
      .BLANK_CYCLES(1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .value   (value),
      .dots    (dots),
      .digit_en(digit_en),
      .abcdefgh(abcdefgh),
      .digit   (digit),
      .scan_idx(scan_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One slot as seen at the outputs: one blank sample, then three lit samples.
   task automatic slot(input string tag, input int sidx, input logic [3:0] dig,
                       input logic [7:0] seg);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 0) begin
            check({tag, " scan"}, 32'(scan_idx), 32'(sidx));
            check({tag, " blank dig"}, 32'(digit), 32'hF);
            check({tag, " blank seg"}, 32'(abcdefgh), 32'hFF);
         end else begin
            check({tag, " dig"}, 32'(digit), 32'(dig));
            check({tag, " seg"}, 32'(abcdefgh), 32'(seg));
         end
      end
   endtask

   // Slot with the digit dark for the whole slot.
   task automatic dark(input string tag, input int sidx);
      slot(tag, sidx, 4'hF, 8'hFF);
   endtask

   task automatic slot_lz(input string tag, input int sidx, input logic [3:0] dig,
                          input logic [7:0] seg);
      if (LZ) dark(tag, sidx);
      else    slot(tag, sidx, dig, seg);
   endtask

   initial begin
      reset    = 1'b1;
      value    = 16'h1234;
      dots     = 4'h0;
      digit_en = 4'hF;

      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("rst seg", 32'(abcdefgh), 32'hFF);
         check("rst dig", 32'(digit), 32'hF);
         check("rst scan", 32'(scan_idx), 32'h0);
      end
      reset = 1'b0;

      // Frame 1: 1234.
      slot("f1 s0", 0, 4'hE, 8'h99);
      slot("f1 s1", 1, 4'hD, 8'h0D);
      slot("f1 s2", 2, 4'hB, 8'h25);
      slot("f1 s3", 3, 4'h7, 8'h9F);

      // Frame 2: change to FFFF after slot0, must stay invisible this frame.
      slot("f2 s0", 0, 4'hE, 8'h99);
      value = 16'hFFFF;
      slot("f2 s1", 1, 4'hD, 8'h0D);
      slot("f2 s2", 2, 4'hB, 8'h25);
      slot("f2 s3", 3, 4'h7, 8'h9F);

      // Frame 3: FFFF.
      slot("f3 s0", 0, 4'hE, 8'h71);
      slot("f3 s1", 1, 4'hD, 8'h71);
      slot("f3 s2", 2, 4'hB, 8'h71);
      slot("f3 s3", 3, 4'h7, 8'h71);
      value    = 16'h0080;
      dots     = 4'b0010;
      digit_en = 4'b1011;

      // Frame 4: dot on digit 1, digit 2 disabled.
      slot("f4 s0", 0, 4'hE, 8'h03);
      slot("f4 s1", 1, 4'hD, 8'h00);
      dark("f4 s2", 2);
      slot_lz("f4 s3", 3, 4'h7, 8'h03);

      // Frame 5: reset for one cycle in slot2, with new inputs for the reload.
      slot("f5 s0", 0, 4'hE, 8'h03);
      slot("f5 s1", 1, 4'hD, 8'h00);
      @(posedge clk);
      @(negedge clk);
      check("pre-rst scan", 32'(scan_idx), 32'h2);
      value    = 16'h1234;
      dots     = 4'h0;
      digit_en = 4'hF;
      reset    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst scan", 32'(scan_idx), 32'h0);
      check("midrst seg", 32'(abcdefgh), 32'hFF);
      check("midrst dig", 32'(digit), 32'hF);
      reset = 1'b0;

      // Frame 6: restart from slot0 with reloaded snapshot.
      slot("f6 s0", 0, 4'hE, 8'h99);
      slot("f6 s1", 1, 4'hD, 8'h0D);
      slot("f6 s2", 2, 4'hB, 8'h25);
      slot("f6 s3", 3, 4'h7, 8'h9F);
      value = 16'h0070;

      // Frame 7: leading zeros.
      slot("f7 s0", 0, 4'hE, 8'h03);
      slot("f7 s1", 1, 4'hD, 8'h1F);
      slot_lz("f7 s2", 2, 4'hB, 8'h03);
      slot_lz("f7 s3", 3, 4'h7, 8'h03);
      value = 16'h0000;

      // Frame 8: all zero.
      slot("f8 s0", 0, 4'hE, 8'h03);
      slot_lz("f8 s1", 1, 4'hD, 8'h03);
      slot_lz("f8 s2", 2, 4'hB, 8'h03);
      slot_lz("f8 s3", 3, 4'h7, 8'h03);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
